rv32_decode_stage: RTL and testbench

- Parametrised RV32I decode pipeline stage: combinational instruction decode followed by an output register with a valid/ready handshake.
- Sits between fetch and the operand-fetch/execute stage.
- Adds the following to the basic decoder:
  - optional M-extension decode;
  - strict illegal-instruction checks on funct3/funct7 and system immediates;
  - registered register addresses and register-usage flags for hazard logic;
  - backpressure and flush.

---
 rtl/rv32_decode_pkg.sv | 82 ++++++++
 rtl/rv32_decode_comb.sv | 172 +++++++++++++++++
 rtl/rv32_decode_stage.sv | 123 ++++++++++++
 tb/tb_rv32_decode_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_decode_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, funct codes,
// one-hot bit positions and the recognised SYSTEM immediates.
package rv32_decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_AND  = 6;
  localparam int ALU_SLL  = 7;
  localparam int ALU_SRL  = 8;
  localparam int ALU_SRA  = 9;
  localparam int ALU_EQ   = 10;
  localparam int ALU_NEQ  = 11;
  localparam int ALU_GE   = 12;
  localparam int ALU_GEU  = 13;
  localparam int ALU_W    = 14;

  localparam int MD_W = 8;  // md_op is indexed directly by funct3

  localparam int OT_RTYPE  = 0;
  localparam int OT_ITYPE  = 1;
  localparam int OT_LOAD   = 2;
  localparam int OT_STORE  = 3;
  localparam int OT_BRANCH = 4;
  localparam int OT_JAL    = 5;
  localparam int OT_JALR   = 6;
  localparam int OT_LUI    = 7;
  localparam int OT_AUIPC  = 8;
  localparam int OT_SYSTEM = 9;
  localparam int OT_FENCE  = 10;
  localparam int OT_W      = 11;

  localparam logic [11:0] SYS_ECALL  = 12'h000;
  localparam logic [11:0] SYS_EBREAK = 12'h001;
  localparam logic [11:0] SYS_MRET   = 12'h302;

  // Register/immediate ALU op; alt is inst[30] already qualified by the caller.
  function automatic logic [ALU_W-1:0] alu_by_f3(input logic [2:0] f3, input logic alt);
    logic [ALU_W-1:0] op;
    op = '0;
    case (f3)
      F3_ADD:  op[alt ? ALU_SUB : ALU_ADD] = 1'b1;
      F3_SLL:  op[ALU_SLL]  = 1'b1;
      F3_SLT:  op[ALU_SLT]  = 1'b1;
      F3_SLTU: op[ALU_SLTU] = 1'b1;
      F3_XOR:  op[ALU_XOR]  = 1'b1;
      F3_SR:   op[alt ? ALU_SRA : ALU_SRL] = 1'b1;
      F3_OR:   op[ALU_OR]   = 1'b1;
      default: op[ALU_AND]  = 1'b1;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I(+M, +Zicsr) instruction decoder with strict
// legality checks; illegal instructions have all side-effect flags cleared.
module rv32_decode_comb
  import rv32_decode_pkg::*;
#(
  parameter int EN_M   = 1,
  parameter int EN_CSR = 1
) (
  input  logic [31:0]       inst,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  output logic [4:0]        rd_addr,
  output logic              rs1_used,
  output logic              rs2_used,
  output logic              rd_we,
  output logic [31:0]       imm,
  output logic [2:0]        funct3,
  output logic [ALU_W-1:0]  alu_op,
  output logic [MD_W-1:0]   md_op,
  output logic [OT_W-1:0]   opcode_type,
  output logic              is_inst_illegal,
  output logic              is_ecall,
  output logic              is_ebreak,
  output logic              is_mret
);

  logic [6:0]  opcode, f7;
  logic [11:0] sys_imm;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode   = inst[6:0];
  assign f7       = inst[31:25];
  assign sys_imm  = inst[31:20];
  assign funct3   = inst[14:12];
  assign rd_addr  = inst[11:7];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'h000};

  always_comb begin
    opcode_type     = '0;
    imm             = '0;
    alu_op          = '0;
    md_op           = '0;
    is_inst_illegal = 1'b0;
    rs1_used        = 1'b0;
    rs2_used        = 1'b0;
    rd_we           = 1'b0;
    is_ecall        = 1'b0;
    is_ebreak       = 1'b0;
    is_mret         = 1'b0;
    case (opcode)
      OPC_OP: begin
        opcode_type[OT_RTYPE] = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        rd_we    = 1'b1;
        if (f7 == F7_BASE)
          alu_op = alu_by_f3(funct3, 1'b0);
        else if (f7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR))
          alu_op = alu_by_f3(funct3, 1'b1);
        else if (f7 == F7_MULDIV && EN_M != 0)
          md_op[funct3] = 1'b1;
        else
          is_inst_illegal = 1'b1;
      end
      OPC_IMM: begin
        opcode_type[OT_ITYPE] = 1'b1;
        rs1_used = 1'b1;
        rd_we    = 1'b1;
        imm      = imm_i;
        // addi never becomes sub; only the right shift honours inst[30]
        alu_op   = alu_by_f3(funct3, funct3 == F3_SR && inst[30]);
        if (funct3 == F3_SLL)
          is_inst_illegal = (f7 != F7_BASE);
        else if (funct3 == F3_SR)
          is_inst_illegal = !(f7 == F7_BASE || f7 == F7_ALT);
      end
      OPC_LOAD: begin
        opcode_type[OT_LOAD] = 1'b1;
        rs1_used = 1'b1;
        rd_we    = 1'b1;
        imm      = imm_i;
        alu_op[ALU_ADD] = 1'b1;
        is_inst_illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
      end
      OPC_STORE: begin
        opcode_type[OT_STORE] = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm      = imm_s;
        alu_op[ALU_ADD] = 1'b1;
        is_inst_illegal = (funct3 >= 3'b011);
      end
      OPC_BRANCH: begin
        opcode_type[OT_BRANCH] = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm      = imm_b;
        case (funct3)
          3'b000:  alu_op[ALU_EQ]   = 1'b1;
          3'b001:  alu_op[ALU_NEQ]  = 1'b1;
          3'b100:  alu_op[ALU_SLT]  = 1'b1;
          3'b101:  alu_op[ALU_GE]   = 1'b1;
          3'b110:  alu_op[ALU_SLTU] = 1'b1;
          3'b111:  alu_op[ALU_GEU]  = 1'b1;
          default: is_inst_illegal  = 1'b1;
        endcase
      end
      OPC_JAL: begin
        opcode_type[OT_JAL] = 1'b1;
        rd_we  = 1'b1;
        imm    = imm_j;
        alu_op[ALU_ADD] = 1'b1;
      end
      OPC_JALR: begin
        opcode_type[OT_JALR] = 1'b1;
        rs1_used = 1'b1;
        rd_we    = 1'b1;
        imm      = imm_i;
        alu_op[ALU_ADD] = 1'b1;
        is_inst_illegal = (funct3 != 3'b000);
      end
      OPC_LUI, OPC_AUIPC: begin
        opcode_type[(opcode == OPC_LUI) ? OT_LUI : OT_AUIPC] = 1'b1;
        rd_we  = 1'b1;
        imm    = imm_u;
        alu_op[ALU_ADD] = 1'b1;
      end
      OPC_SYSTEM: begin
        opcode_type[OT_SYSTEM] = 1'b1;
        imm    = {20'h0, sys_imm};
        alu_op[ALU_ADD] = 1'b1;
        if (funct3 == 3'b000) begin
          case (sys_imm)
            SYS_ECALL:  is_ecall  = 1'b1;
            SYS_EBREAK: is_ebreak = 1'b1;
            SYS_MRET:   is_mret   = 1'b1;
            default:    is_inst_illegal = 1'b1;
          endcase
        end else if (funct3 == 3'b100 || EN_CSR == 0) begin
          is_inst_illegal = 1'b1;
        end else begin
          rd_we    = 1'b1;
          rs1_used = !funct3[2];  // immediate CSR forms carry uimm in rs1
        end
      end
      OPC_FENCE: begin
        opcode_type[OT_FENCE] = 1'b1;
        imm    = {20'h0, sys_imm};
        alu_op[ALU_ADD] = 1'b1;
      end
      default: is_inst_illegal = 1'b1;
    endcase

    if (is_inst_illegal) begin
      alu_op   = '0;
      md_op    = '0;
      rd_we    = 1'b0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
    end
    if (rd_addr == 5'd0)
      rd_we = 1'b0;
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode pipeline stage: combinational decode into a single output
// register slice with valid/ready handshake and flush.
module rv32_decode_stage
  import rv32_decode_pkg::*;
#(
  parameter int EN_M   = 1,
  parameter int EN_CSR = 1,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  output logic [4:0]        rd_addr,
  output logic              rs1_used,
  output logic              rs2_used,
  output logic              rd_we,
  output logic [XLEN-1:0]   imm,
  output logic [2:0]        funct3,
  output logic [13:0]       alu_op,
  output logic [7:0]        md_op,
  output logic [10:0]       opcode_type,
  output logic              is_inst_illegal,
  output logic              is_inst_addr_misaligned,
  output logic              is_ecall,
  output logic              is_ebreak,
  output logic              is_mret
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("rv32_decode_stage: only XLEN=32 is supported");
  end

  logic [4:0]        d_rs1, d_rs2, d_rd;
  logic              d_rs1_used, d_rs2_used, d_rd_we;
  logic [31:0]       d_imm;
  logic [2:0]        d_funct3;
  logic [ALU_W-1:0]  d_alu;
  logic [MD_W-1:0]   d_md;
  logic [OT_W-1:0]   d_otype;
  logic              d_illegal, d_ecall, d_ebreak, d_mret;
  logic              load;

  rv32_decode_comb #(.EN_M(EN_M), .EN_CSR(EN_CSR)) u_comb (
    .inst            (in_inst),
    .rs1_addr        (d_rs1),
    .rs2_addr        (d_rs2),
    .rd_addr         (d_rd),
    .rs1_used        (d_rs1_used),
    .rs2_used        (d_rs2_used),
    .rd_we           (d_rd_we),
    .imm             (d_imm),
    .funct3          (d_funct3),
    .alu_op          (d_alu),
    .md_op           (d_md),
    .opcode_type     (d_otype),
    .is_inst_illegal (d_illegal),
    .is_ecall        (d_ecall),
    .is_ebreak       (d_ebreak),
    .is_mret         (d_mret)
  );

  assign in_ready = flush | !out_valid | out_ready;
  // Payload only moves on an accepted, non-flushed transfer, so it is
  // bit-stable whenever the slot is stalled.
  assign load     = in_valid & in_ready & !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              out_valid <= 1'b0;
    else if (flush)          out_valid <= 1'b0;
    else if (load)           out_valid <= 1'b1;
    else if (out_ready)      out_valid <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc                  <= '0;
      rs1_addr                <= '0;
      rs2_addr                <= '0;
      rd_addr                 <= '0;
      rs1_used                <= 1'b0;
      rs2_used                <= 1'b0;
      rd_we                   <= 1'b0;
      imm                     <= '0;
      funct3                  <= '0;
      alu_op                  <= '0;
      md_op                   <= '0;
      opcode_type             <= '0;
      is_inst_illegal         <= 1'b0;
      is_inst_addr_misaligned <= 1'b0;
      is_ecall                <= 1'b0;
      is_ebreak               <= 1'b0;
      is_mret                 <= 1'b0;
    end else if (load) begin
      out_pc                  <= in_pc;
      rs1_addr                <= d_rs1;
      rs2_addr                <= d_rs2;
      rd_addr                 <= d_rd;
      rs1_used                <= d_rs1_used;
      rs2_used                <= d_rs2_used;
      rd_we                   <= d_rd_we;
      imm                     <= d_imm;
      funct3                  <= d_funct3;
      alu_op                  <= d_alu;
      md_op                   <= d_md;
      opcode_type             <= d_otype;
      is_inst_illegal         <= d_illegal;
      is_inst_addr_misaligned <= (in_pc[1:0] != 2'b00);
      is_ecall                <= d_ecall;
      is_ebreak               <= d_ebreak;
      is_mret                 <= d_mret;
    end
  end

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed bench for rv32_decode_stage: one default instance and one with
// EN_M=0 driven by the same stimulus.
module tb_rv32_decode_stage;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_inst;

  logic        in_ready, out_valid, rs1_used, rs2_used, rd_we;
  logic [31:0] out_pc, imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [2:0]  funct3;
  logic [13:0] alu_op;
  logic [7:0]  md_op;
  logic [10:0] opcode_type;
  logic        illegal, misal, ecall, ebreak, mret;

  logic        n_in_ready, n_out_valid, n_rs1_used, n_rs2_used, n_rd_we;
  logic [31:0] n_out_pc, n_imm;
  logic [4:0]  n_rs1_addr, n_rs2_addr, n_rd_addr;
  logic [2:0]  n_funct3;
  logic [13:0] n_alu_op;
  logic [7:0]  n_md_op;
  logic [10:0] n_opcode_type;
  logic        n_illegal, n_misal, n_ecall, n_ebreak, n_mret;

  int total = 0;
  int bad   = 0;

  rv32_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_we(rd_we), .imm(imm), .funct3(funct3),
    .alu_op(alu_op), .md_op(md_op), .opcode_type(opcode_type), .is_inst_illegal(illegal),
    .is_inst_addr_misaligned(misal), .is_ecall(ecall), .is_ebreak(ebreak), .is_mret(mret)
  );

  rv32_decode_stage #(.EN_M(0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_out_pc), .rs1_addr(n_rs1_addr), .rs2_addr(n_rs2_addr), .rd_addr(n_rd_addr),
    .rs1_used(n_rs1_used), .rs2_used(n_rs2_used), .rd_we(n_rd_we), .imm(n_imm),
    .funct3(n_funct3), .alu_op(n_alu_op), .md_op(n_md_op), .opcode_type(n_opcode_type),
    .is_inst_illegal(n_illegal), .is_inst_addr_misaligned(n_misal), .is_ecall(n_ecall),
    .is_ebreak(n_ebreak), .is_mret(n_mret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imm", imm, 0);
    chk("rst_otype", opcode_type, 0);
    #10 rst_n = 1'b1;

    // addi x1,x0,-1
    out_ready = 1'b1;
    drive(32'hFFF00093, 32'h100);
    step();
    chk("addi_valid", out_valid, 1);
    chk("addi_otype", opcode_type, 32'h002);
    chk("addi_alu", alu_op, 32'h0001);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_rd", rd_addr, 1);
    chk("addi_rd_we", rd_we, 1);
    chk("addi_rs1u", rs1_used, 1);
    chk("addi_rs2u", rs2_used, 0);
    chk("addi_illegal", illegal, 0);
    chk("addi_misal", misal, 0);
    chk("addi_pc", out_pc, 32'h100);

    // mul x3,x1,x2
    drive(32'h022081B3, 32'h104);
    step();
    chk("mul_md", md_op, 32'h01);
    chk("mul_alu", alu_op, 0);
    chk("mul_rd_we", rd_we, 1);
    chk("mul_illegal", illegal, 0);
    chk("mul_nm_illegal", n_illegal, 1);
    chk("mul_nm_rd_we", n_rd_we, 0);
    chk("mul_nm_md", n_md_op, 0);
    chk("mul_nm_otype", n_opcode_type, 32'h001);

    // backpressure: addi held while add x5,x6,x7 waits
    drive(32'hFFF00093, 32'h108);
    step();
    out_ready = 1'b0;
    drive(32'h007302B3, 32'h10C);
    #1;
    chk("bp_in_ready0", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_rd", rd_addr, 1);
      chk("bp_imm", imm, 32'hFFFFFFFF);
      chk("bp_pc", out_pc, 32'h108);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    chk("add_rd", rd_addr, 5);
    chk("add_rs2u", rs2_used, 1);
    chk("add_imm", imm, 0);
    chk("add_pc", out_pc, 32'h10C);

    // flush while holding and presenting
    out_ready = 1'b0;
    flush     = 1'b1;
    drive(32'hFE20DEE3, 32'h110);
    #1;
    chk("flush_in_ready", in_ready, 1);
    step();
    chk("flush_valid", out_valid, 0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("flush_dropped", out_valid, 0);

    // bge x1,x2,-4
    out_ready = 1'b1;
    drive(32'hFE20DEE3, 32'h114);
    step();
    chk("bge_valid", out_valid, 1);
    chk("bge_alu", alu_op, 32'h1000);
    chk("bge_imm", imm, 32'hFFFFFFFC);
    chk("bge_otype", opcode_type, 32'h010);
    chk("bge_rs2u", rs2_used, 1);
    chk("bge_rd_we", rd_we, 0);

    // sw x2,8(x1)
    drive(32'h0020A423, 32'h118);
    step();
    chk("sw_imm", imm, 8);
    chk("sw_otype", opcode_type, 32'h008);
    chk("sw_rd_we", rd_we, 0);
    chk("sw_funct3", funct3, 2);

    drive(32'h00000073, 32'h11C);
    step();
    chk("ecall", ecall, 1);
    chk("ecall_otype", opcode_type, 32'h200);
    chk("ecall_illegal", illegal, 0);
    drive(32'h00100073, 32'h120);
    step();
    chk("ebreak", ebreak, 1);
    chk("ebreak_ecall", ecall, 0);
    drive(32'h30200073, 32'h124);
    step();
    chk("mret", mret, 1);
    chk("mret_imm", imm, 32'h302);
    drive(32'h10500073, 32'h128);
    step();
    chk("wfi_illegal", illegal, 1);
    chk("wfi_flags", {ecall, ebreak, mret}, 0);
    chk("wfi_otype", opcode_type, 32'h200);

    drive(32'h00000000, 32'h12C);
    step();
    chk("zero_illegal", illegal, 1);
    chk("zero_otype", opcode_type, 0);
    chk("zero_alu", alu_op, 0);

    drive(32'hFFF00093, 32'h102);
    step();
    chk("misal", misal, 1);
    chk("misal_pc", out_pc, 32'h102);
    chk("misal_illegal", illegal, 0);

    // asynchronous reset between edges
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_imm", imm, 0);
    chk("arst_rd", rd_addr, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_misal", misal, 0);
    chk("arst_otype", opcode_type, 0);
    chk("arst_alu", alu_op, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
